// File: rtl/updown_counter_if.sv
// Button/status bundle between the conditioned button inputs and updown_counter.
// The master side drives buttons; the slave (counter) drives the status outputs.
interface updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [3:0]       buttons;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             dir_up;
  logic             tick;

  modport master (output buttons, input count, running, dir_up, tick);
  modport slave  (input buttons, output count, running, dir_up, tick);
endinterface

// File: rtl/updown_counter.sv
// Edge-triggered LED counter: manual stepping in pause mode, prescaled
// automatic stepping in run mode, wrap or saturate at the count limits.
module updown_counter #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned CYCLES_PER_TICK = 125_000_000,
  parameter bit          SATURATE        = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  updown_counter_if.slave bus
);

  localparam int unsigned PW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CYCLES_PER_TICK - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};

  logic [3:0]       btn_prev;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             running_q, running_nxt;
  logic             dir_up_q, dir_up_nxt;
  logic             tick_q, tick_nxt;
  logic [PW-1:0]    presc_q, presc_nxt;

  logic [3:0]       press_c;
  logic [WIDTH-1:0] count_inc_c, count_dec_c;
  logic             presc_wrap_c;

  // Rising-edge detect and the two candidate step results
  always_comb begin
    press_c      = bus.buttons & ~btn_prev;
    count_inc_c  = (SATURATE && count_q == COUNT_MAX) ? COUNT_MAX : count_q + WIDTH'(1);
    count_dec_c  = (SATURATE && count_q == '0) ? '0 : count_q - WIDTH'(1);
    presc_wrap_c = (presc_q == PRESC_LAST);
  end

  // Next-state decode; every press is interpreted under the pre-toggle mode
  always_comb begin
    count_nxt   = count_q;
    running_nxt = running_q ^ press_c[2];
    dir_up_nxt  = dir_up_q;
    tick_nxt    = 1'b0;
    presc_nxt   = '0;

    if (!running_q) begin
      if (press_c[3])      count_nxt = '0;
      else if (press_c[0]) count_nxt = count_inc_c;
      else if (press_c[1]) count_nxt = count_dec_c;
    end else begin
      if (presc_wrap_c) begin
        tick_nxt  = 1'b1;
        count_nxt = dir_up_q ? count_inc_c : count_dec_c;
      end else begin
        presc_nxt = presc_q + PW'(1);
      end

      if (press_c[0])      dir_up_nxt = 1'b1;
      else if (press_c[1]) dir_up_nxt = 1'b0;

      // Clear beats the tick step but leaves the tick pulse intact
      if (press_c[3]) begin
        count_nxt = '0;
        presc_nxt = '0;
      end

      // Leaving run mode parks the prescaler so re-entry gets a full period
      if (press_c[2]) presc_nxt = '0;
    end
  end

  // btn_prev resets high so a button held through reset does not fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev  <= 4'b1111;
      count_q   <= '0;
      running_q <= 1'b0;
      dir_up_q  <= 1'b1;
      tick_q    <= 1'b0;
      presc_q   <= '0;
    end else begin
      btn_prev  <= bus.buttons;
      count_q   <= count_nxt;
      running_q <= running_nxt;
      dir_up_q  <= dir_up_nxt;
      tick_q    <= tick_nxt;
      presc_q   <= presc_nxt;
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.dir_up  = dir_up_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench: three counter instances (wrap/CPT=4, saturate/CPT=4,
// wrap/CPT=1) share one button stream; expectations are hand-derived.
module tb_updown_counter;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  int         checks;
  int         errors;

  updown_counter_if #(.WIDTH(4)) bw ();
  updown_counter_if #(.WIDTH(4)) bs ();
  updown_counter_if #(.WIDTH(4)) bf ();

  assign bw.buttons = btn;
  assign bs.buttons = btn;
  assign bf.buttons = btn;

  updown_counter #(.WIDTH(4), .CYCLES_PER_TICK(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .bus(bw));
  updown_counter #(.WIDTH(4), .CYCLES_PER_TICK(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .bus(bs));
  updown_counter #(.WIDTH(4), .CYCLES_PER_TICK(1), .SATURATE(1'b0)) u_fast (
    .clk(clk), .rst(rst), .bus(bf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    cyc(1);
    btn = 4'b0000;
    cyc(1);
  endtask

  // n cycles with tick low throughout
  task automatic quiet(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      cyc(1);
      chk(tag, 32'(bw.tick), 0);
    end
  endtask

  // n cycles with tick high only on the last, then check the stepped count
  task automatic run_wait(input int n, input int exp_count, input string tag);
    for (int i = 1; i <= n; i++) begin
      cyc(1);
      chk({tag, "_tick"}, 32'(bw.tick), (i == n) ? 1 : 0);
    end
    chk({tag, "_count"}, 32'(bw.count), exp_count);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    btn    = 4'b0001;

    // Reset values, with up held through reset release
    cyc(2);
    chk("rst_count",   32'(bw.count),   0);
    chk("rst_running", 32'(bw.running), 0);
    chk("rst_dir_up",  32'(bw.dir_up),  1);
    chk("rst_tick",    32'(bw.tick),    0);
    rst = 1'b0;
    cyc(3);
    chk("held_no_fire", 32'(bw.count), 0);
    btn = 4'b0000;
    cyc(2);
    btn = 4'b0001;
    cyc(1);
    chk("press_latency", 32'(bw.count), 1);
    cyc(9);
    chk("held_one_step", 32'(bw.count), 1);
    btn = 4'b0000;
    cyc(1);

    // Pause-mode wrap versus saturate
    press(4'b1000);
    chk("clear_pause", 32'(bw.count), 0);
    press(4'b0010);
    chk("wrap_down",  32'(bw.count), 15);
    chk("sat_down",   32'(bs.count), 0);
    press(4'b0001);
    chk("wrap_up",    32'(bw.count), 0);
    chk("sat_up",     32'(bs.count), 1);
    repeat (13) press(4'b0001);
    chk("sat_at_14",  32'(bs.count), 14);
    press(4'b0001);
    chk("sat_15_a",   32'(bs.count), 15);
    press(4'b0001);
    chk("sat_15_b",   32'(bs.count), 15);
    press(4'b0001);
    chk("sat_15_c",   32'(bs.count), 15);
    chk("wrap_at_0",  32'(bw.count), 0);
    chk("fast_at_0",  32'(bf.count), 0);

    // Enter run mode at edge k; ticks at k+4, k+8, k+12
    btn = 4'b0100;
    cyc(1);
    chk("run_enter", 32'(bw.running), 1);
    chk("run_enter_tick", 32'(bw.tick), 0);
    btn = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      chk("run_tick",  32'(bw.tick),  (i % 4 == 0) ? 1 : 0);
      chk("run_count", 32'(bw.count), i / 4);
      if (i == 1 || i == 5) begin
        chk("fast_tick",  32'(bf.tick),  1);
        chk("fast_count", 32'(bf.count), i);
      end
      if (i == 4) begin
        chk("sat_run_tick",  32'(bs.tick),  1);
        chk("sat_run_count", 32'(bs.count), 15);
      end
    end

    // Direction change and clear while running
    btn = 4'b0010;
    cyc(1);
    chk("dir_down", 32'(bw.dir_up), 0);
    chk("dir_no_step", 32'(bw.count), 3);
    btn = 4'b0000;
    run_wait(3, 2, "down_a");
    run_wait(4, 1, "down_b");
    quiet(3, "pre_clear");
    btn = 4'b1000;
    cyc(1);
    chk("clear_on_tick_count", 32'(bw.count), 0);
    chk("clear_on_tick_tick",  32'(bw.tick),  1);
    btn = 4'b0000;
    run_wait(4, 15, "wrap_after_clear");
    quiet(1, "mid_period");
    btn = 4'b1000;
    cyc(1);
    chk("mid_clear_count", 32'(bw.count), 0);
    btn = 4'b0000;
    run_wait(4, 15, "presc_restart");

    // Back to pause: tick stays low, count frozen
    btn = 4'b0100;
    cyc(1);
    chk("pause_enter", 32'(bw.running), 0);
    btn = 4'b0000;
    quiet(6, "pause_quiet");
    chk("pause_hold", 32'(bw.count), 15);

    // Priority in pause mode
    press(4'b1000);
    repeat (5) press(4'b0001);
    chk("prio_setup", 32'(bw.count), 5);
    press(4'b1001);
    chk("prio_clear_over_up", 32'(bw.count), 0);
    repeat (5) press(4'b0001);
    press(4'b0011);
    chk("prio_up_over_down", 32'(bw.count), 6);
    repeat (2) press(4'b0001);
    btn = 4'b0101;
    cyc(1);
    chk("toggle_up_count",   32'(bw.count),   9);
    chk("toggle_up_running", 32'(bw.running), 1);
    btn = 4'b0000;
    cyc(1);
    btn = 4'b0001;
    cyc(1);
    chk("run_dir_up", 32'(bw.dir_up), 1);
    chk("run_up_no_step", 32'(bw.count), 9);
    btn = 4'b0000;
    cyc(1);

    // Asynchronous reset between edges, one cycle before a tick would land
    #3 rst = 1'b1;
    #1;
    chk("async_count",   32'(bw.count),   0);
    chk("async_running", 32'(bw.running), 0);
    chk("async_dir_up",  32'(bw.dir_up),  1);
    #2 rst = 1'b0;
    quiet(12, "post_reset_quiet");
    chk("post_reset_count",   32'(bw.count),   0);
    chk("post_reset_running", 32'(bw.running), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised, edge-triggered LED counter with run/pause modes, selectable direction and wrap-or-saturate arithmetic. It generalises the lab button counter: arbitrary count width, a configurable tick period, and one-shot button handling. It sits between the board's conditioned button inputs (already synchronised and debounced upstream) and the LED bank or any status display.

## Interface
- `WIDTH`, 4, count width in bits (≥1).
- `CYCLES_PER_TICK`, 125_000_000, clock cycles per automatic step in run mode (≥1).
- `SATURATE`, 0, 0 = modular wrap at the limits, 1 = hold at 0 / 2^WIDTH−1.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `buttons`  input  4  level buttons: [0] up, [1] down, [2] run/pause toggle, [3] clear.
- `count`  output  WIDTH  current count value (registered).
- `running`  output  1  1 = run mode, 0 = pause mode (registered).
- `dir_up`  output  1  run-mode direction: 1 = up, 0 = down (registered).
- `tick`  output  1  one-cycle pulse marking an automatic step (registered).

## Operation
- Edge detection: `btn_prev` registers `buttons` every cycle. `press[i] = buttons[i] & ~btn_prev[i]`. Only `press` acts, so a held button acts exactly once.
- Mode: `press[2]` toggles `running`.
- Pause mode (`running`=0):
  - Prescaler is held at 0 and `tick` stays 0.
  - `press[3]`: count ← 0.
  - Otherwise `press[0]`: count ← count+1.
  - Otherwise `press[1]`: count ← count−1.
  - Priority is 3 > 0 > 1.
- Run mode (`running`=1):
  - Prescaler counts 0..CYCLES_PER_TICK−1 and wraps to 0. Its width is $clog2(CYCLES_PER_TICK), minimum 1.
  - On the wrap cycle, `tick` pulses and count steps by ±1 according to `dir_up`.
  - `press[0]` sets `dir_up`=1 and `press[1]` sets `dir_up`=0. In run mode these presses do not step the count. If both occur in the same cycle, up wins.
  - `press[3]` sets count ← 0 and prescaler ← 0. It overrides a coincident tick step, but `tick` still pulses.
- Arithmetic:
  - With SATURATE=0, steps are modulo 2^WIDTH: max+1 → 0 and 0−1 → max.
  - With SATURATE=1, an up step at max holds max and a down step at 0 holds 0. This applies to both manual and tick steps.
- Simultaneous events:
  - If `press[2]` coincides with another press, the other press is decoded under the mode in effect before the toggle.
  - If a direction press coincides with a tick, the tick step uses the old `dir_up`.
  - Leaving run mode clears the prescaler. Re-entering run mode starts a full CYCLES_PER_TICK period.

## Timing
- Reset values: count=0, running=0, dir_up=1, tick=0, prescaler=0, btn_prev=4'b1111.
  - Because `btn_prev` resets to all ones, a button held through reset release does not fire. It must be released and pressed again.
  - Asserting reset mid-operation clears all state immediately, without waiting for a clock edge.
- Press latency: if a button is first seen high at rising edge k, `count`/`running`/`dir_up` change at edge k and are visible in cycle k+1.
- Tick period: after entering run mode at edge k (prescaler=0), the first tick and step occur at edge k+CYCLES_PER_TICK. Later ticks are exactly CYCLES_PER_TICK cycles apart. `tick` is high for exactly one cycle, in the cycle `count` shows the new value.
- With CYCLES_PER_TICK=1: `tick` stays high and count steps every cycle while running.
- No combinational path from `buttons` to any output.

## Test plan
- Reset/held button: WIDTH=4. Hold buttons=4'b0001 across reset release → count stays 0. Release, then press once for 10 cycles → count=1, one step only.
- Pause wrap/saturate: SATURATE=0, count=0, press[1] → count=15. Then press[0] → 0. With SATURATE=1, count=0, press[1] → 0. Three presses of [0] from 14 → 15, 15, 15.
- Run timing: CYCLES_PER_TICK=4, press[2] at edge k → tick at k+4, k+8, k+12. count=1, 2, 3. tick is low on all other cycles.
- Direction and clear: while running at count=3, press[1] → next tick gives 2, then 1. Press[3] coincident with a tick → count=0, prescaler restarts, next tick 4 cycles later gives 15 (down, wrap).
- Priority: in pause, buttons 0 and 3 rising together from count=5 → count=0. Buttons 0 and 1 together → count=6. Press[2] with press[0] in pause → count+1 and running=1.
- Async reset mid-run: assert `rst` between edges while count=9 and running=1 → outputs return to reset values before the next edge. After release, the next tick does not occur until a new press[2].
